// File: rtl/uart_cmd_pkg.sv
// Shared encoding for the UART drive-command link: command codes, ASCII framing
// constants and the baud divider helper used by both ends of the link.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        CmdStop  = 3'd0,
        CmdFwd   = 3'd1,
        CmdBack  = 3'd2,
        CmdLeft  = 3'd3,
        CmdRight = 3'd4
    } cmd_e;

    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_L    = 8'h4C;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop line synchronizer, mid-bit sampling FSM, one-cycle
// byte_valid / frame_error pulses registered one cycle after the stop-bit sample.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HalfBit    = ClksPerBit / 2;
    localparam int unsigned CntW       = $clog2(ClksPerBit + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    rx_state_e       state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CntW-1:0] clk_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_error_q, frame_error_d;
    logic            rx, half_tick, bit_tick;

    assign rx        = sync2_q;
    assign half_tick = (clk_cnt_q == CntW'(HalfBit - 1));
    assign bit_tick  = (clk_cnt_q == CntW'(ClksPerBit - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!rx) state_d = StStart;
            StStart: if (half_tick) state_d = rx ? StIdle : StData;
            StData:  if (bit_tick && bit_cnt_q == 3'd7) state_d = StStop;
            StStop:  if (bit_tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_valid_d  = (state_q == StStop) && bit_tick && rx;
        frame_error_d = (state_q == StStop) && bit_tick && !rx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            clk_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sync1_q       <= uart_in;
            sync2_q       <= sync1_q;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
            unique case (state_q)
                StIdle: begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                end
                StStart: clk_cnt_q <= half_tick ? '0 : clk_cnt_q + CntW'(1);
                StData: begin
                    if (bit_tick) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CntW'(1);
                    end
                end
                StStop:  clk_cnt_q <= bit_tick ? '0 : clk_cnt_q + CntW'(1);
                default: clk_cnt_q <= '0;
            endcase
        end
    end

    assign byte_data   = shift_q;
    assign byte_valid  = byte_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: rtl/uart_cmd_receiver.sv
// Base-side drive command receiver: UART bytes -> two-byte ASCII packet parser ->
// held command/multiplier presented over a valid/ready handshake.
module uart_cmd_receiver
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_in,
    output logic [2:0] command,
    output logic [2:0] multiplier,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       frame_error,
    output logic       bad_packet,
    output logic       overrun
);

    typedef enum logic [0:0] {StWaitCmd, StWaitMult} parse_state_e;

    logic [7:0]   rx_data;
    logic         rx_valid, rx_frame_error;
    parse_state_e state_q, state_d;
    cmd_e         cmd_latch_q, letter_code;
    logic         is_letter, is_digit;
    logic         pkt_done, bad_d;
    logic [2:0]   command_q, multiplier_q;
    logic         cmd_valid_q, bad_packet_q, overrun_q;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_in     (uart_in),
        .byte_data   (rx_data),
        .byte_valid  (rx_valid),
        .frame_error (rx_frame_error)
    );

    always_comb begin
        is_letter   = 1'b1;
        letter_code = CmdStop;
        case (rx_data)
            ASCII_S: letter_code = CmdStop;
            ASCII_F: letter_code = CmdFwd;
            ASCII_B: letter_code = CmdBack;
            ASCII_L: letter_code = CmdLeft;
            ASCII_R: letter_code = CmdRight;
            default: is_letter = 1'b0;
        endcase
    end

    assign is_digit = ((rx_data & 8'hF8) == ASCII_ZERO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StWaitCmd;
            cmd_latch_q <= CmdStop;
        end else begin
            state_q <= state_d;
            if (state_q == StWaitCmd && rx_valid && is_letter) begin
                cmd_latch_q <= letter_code;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitCmd:  if (rx_valid && is_letter) state_d = StWaitMult;
            // Any byte (good or bad) or a framing error ends the packet attempt.
            StWaitMult: if (rx_valid || rx_frame_error) state_d = StWaitCmd;
            default:    state_d = StWaitCmd;
        endcase
    end

    always_comb begin
        pkt_done = (state_q == StWaitMult) && rx_valid && is_digit;
        bad_d    = rx_valid && ((state_q == StWaitCmd) ? !is_letter : !is_digit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            command_q    <= '0;
            multiplier_q <= '0;
            cmd_valid_q  <= 1'b0;
            bad_packet_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bad_packet_q <= bad_d;
            overrun_q    <= 1'b0;
            if (pkt_done && (!cmd_valid_q || cmd_ready)) begin
                command_q    <= cmd_latch_q;
                multiplier_q <= rx_data[2:0];
                cmd_valid_q  <= 1'b1;
            end else if (pkt_done) begin
                overrun_q <= 1'b1;
            end else if (cmd_ready) begin
                cmd_valid_q <= 1'b0;
            end
        end
    end

    assign command     = command_q;
    assign multiplier  = multiplier_q;
    assign cmd_valid   = cmd_valid_q;
    assign frame_error = rx_frame_error;
    assign bad_packet  = bad_packet_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Scoreboard bench for uart_cmd_receiver: serial stimulus pushes expected packets,
// a monitor pops them as the DUT loads its output register; pulse counts are modelled.
module tb_uart_cmd_receiver;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 250_000;
    localparam int unsigned CPB      = CLK_FREQ / BAUD;

    typedef struct packed {
        logic [2:0] cmd;
        logic [2:0] mult;
    } pkt_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       uart_in;
    logic [2:0] command, multiplier;
    logic       cmd_valid, cmd_ready;
    logic       frame_error, bad_packet, overrun;

    pkt_t exp_q[$];
    int   n_checks = 0, n_errors = 0;
    int   n_frame = 0, n_bad = 0, n_ovr = 0, n_bytes = 0;
    int   exp_frame = 0, exp_bad = 0, exp_ovr = 0;
    logic prev_valid = 1'b0;

    uart_cmd_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_in     (uart_in),
        .command     (command),
        .multiplier  (multiplier),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .frame_error (frame_error),
        .bad_packet  (bad_packet),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [2:0] c, input logic [2:0] m);
        pkt_t p;
        p.cmd  = c;
        p.mult = m;
        exp_q.push_back(p);
    endtask

    // When ack is set, cmd_ready is raised exactly in the packet-completion cycle.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic ack);
        logic armed;
        uart_in = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            idle(CPB);
        end
        uart_in = stop_bit;
        armed   = ack;
        for (int i = 0; i < (stop_bit ? CPB : (CPB * 3) / 4); i++) begin
            @(negedge clk);
            if (armed && cmd_ready) begin
                cmd_ready = 1'b0;
                armed     = 1'b0;
            end else if (armed && dut.u_rx.byte_valid) begin
                cmd_ready = 1'b1;
            end
        end
        uart_in = 1'b1;
        if (ack) check_eq("ack_in_completion_cycle", {31'd0, armed}, 32'd0);
    endtask

    task automatic consume();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    always @(posedge clk) begin
        logic rdy;
        pkt_t e;
        rdy = cmd_ready;
        #1;
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (frame_error) n_frame++;
            if (bad_packet) n_bad++;
            if (overrun) n_ovr++;
            if (dut.u_rx.byte_valid) n_bytes++;
            if (cmd_valid && (!prev_valid || rdy)) begin
                check_eq("packet_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("command", {29'd0, command}, {29'd0, e.cmd});
                    check_eq("multiplier", {29'd0, multiplier}, {29'd0, e.mult});
                end
            end
            prev_valid = cmd_valid;
        end
    end

    initial begin
        int b0, f0;
        uart_in   = 1'b1;
        cmd_ready = 1'b0;
        reset_n   = 1'b0;
        idle(3);
        check_eq("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check_eq("rst_outputs", {20'd0, command, multiplier, frame_error, bad_packet, overrun},
                 32'd0);
        reset_n = 1'b1;
        idle(5);

        // 'F','3' held while cmd_ready is low, then consumed with a 1-cycle ready.
        push(3'd1, 3'd3);
        send_byte(8'h46, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        idle(30);
        check_eq("t1_valid_held", {31'd0, cmd_valid}, 32'd1);
        check_eq("t1_command", {29'd0, command}, 32'd1);
        consume();
        check_eq("t1_valid_cleared", {31'd0, cmd_valid}, 32'd0);

        // Framing error on 'R' in WAIT_CMD, then a clean 'R','7'.
        send_byte(8'h52, 1'b0, 1'b0);
        exp_frame++;
        idle(CPB);
        check_eq("t2_frame_cnt", n_frame, exp_frame);
        check_eq("t2_no_valid", {31'd0, cmd_valid}, 32'd0);
        check_eq("t2_no_bad", n_bad, exp_bad);
        push(3'd4, 3'd7);
        send_byte(8'h52, 1'b1, 1'b0);
        send_byte(8'h37, 1'b1, 1'b0);
        idle(10);
        check_eq("t2_valid", {31'd0, cmd_valid}, 32'd1);
        consume();

        // Framing error in WAIT_MULT drops the packet silently; '7' is then illegal.
        send_byte(8'h46, 1'b1, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        exp_frame++;
        idle(CPB);
        check_eq("t2b_frame_cnt", n_frame, exp_frame);
        check_eq("t2b_no_bad", n_bad, exp_bad);
        send_byte(8'h37, 1'b1, 1'b0);
        exp_bad++;
        idle(10);
        check_eq("t2b_bad_cnt", n_bad, exp_bad);
        check_eq("t2b_no_valid", {31'd0, cmd_valid}, 32'd0);

        // Short low glitch on an idle line: no byte, no error.
        b0 = n_bytes;
        f0 = n_frame;
        uart_in = 1'b0;
        idle(60);
        uart_in = 1'b1;
        idle(2 * CPB);
        check_eq("t3_no_byte", n_bytes, b0);
        check_eq("t3_no_frame", n_frame, f0);
        push(3'd0, 3'd0);
        send_byte(8'h53, 1'b1, 1'b0);
        send_byte(8'h30, 1'b1, 1'b0);
        idle(10);
        check_eq("t3_valid", {31'd0, cmd_valid}, 32'd1);
        consume();

        // 'X' illegal, 'L' then '9' illegal, 'L','0' good.
        send_byte(8'h58, 1'b1, 1'b0);
        exp_bad++;
        send_byte(8'h4C, 1'b1, 1'b0);
        send_byte(8'h39, 1'b1, 1'b0);
        exp_bad++;
        idle(10);
        check_eq("t4_bad_cnt", n_bad, exp_bad);
        push(3'd3, 3'd0);
        send_byte(8'h4C, 1'b1, 1'b0);
        send_byte(8'h30, 1'b1, 1'b0);
        idle(10);
        check_eq("t4_valid", {31'd0, cmd_valid}, 32'd1);
        consume();

        // Overrun: 'F','1' held, 'B','2' dropped.
        push(3'd1, 3'd1);
        send_byte(8'h46, 1'b1, 1'b0);
        send_byte(8'h31, 1'b1, 1'b0);
        send_byte(8'h42, 1'b1, 1'b0);
        send_byte(8'h32, 1'b1, 1'b0);
        exp_ovr++;
        idle(10);
        check_eq("t5_ovr_cnt", n_ovr, exp_ovr);
        check_eq("t5_held", {26'd0, command, multiplier}, {26'd0, 3'd1, 3'd1});
        check_eq("t5_held_valid", {31'd0, cmd_valid}, 32'd1);
        // Ready in the completion cycle: new packet replaces the old one, no overrun.
        push(3'd2, 3'd2);
        send_byte(8'h42, 1'b1, 1'b0);
        send_byte(8'h32, 1'b1, 1'b1);
        idle(10);
        check_eq("t5_reload_valid", {31'd0, cmd_valid}, 32'd1);
        check_eq("t5_reload", {26'd0, command, multiplier}, {26'd0, 3'd2, 3'd2});
        check_eq("t5_no_ovr", n_ovr, exp_ovr);

        // Asynchronous reset in the middle of a data bit of 'F'.
        uart_in = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            uart_in = (i == 1 || i == 2) ? 1'b1 : 1'b0;
            idle(CPB);
        end
        uart_in = 1'b0;
        idle(CPB / 2);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_async_rst", {23'd0, command, multiplier, cmd_valid, bad_packet, overrun},
                 32'd0);
        uart_in = 1'b1;
        idle(4);
        reset_n = 1'b1;
        idle(2 * CPB);
        push(3'd1, 3'd5);
        send_byte(8'h46, 1'b1, 1'b0);
        send_byte(8'h35, 1'b1, 1'b0);
        idle(10);
        check_eq("t6_valid", {31'd0, cmd_valid}, 32'd1);
        consume();

        idle(20);
        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
        check_eq("final_frame_cnt", n_frame, exp_frame);
        check_eq("final_bad_cnt", n_bad, exp_bad);
        check_eq("final_ovr_cnt", n_ovr, exp_ovr);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
